rg_mac_seq: RTL and testbench

- Sequencer and multiply-accumulate stage directly downstream of the weight ROM (rg_buffer).
- Drives the ROM row address and consumes one input activation per row through a valid/ready stream.
- Accumulates UNITS_NUM parallel dot products across all ROWS rows.
- Presents the fixed-point results as one saturated vector, held under a valid/ready output handshake, to the LSTM gate logic.

---
 rtl/rg_mac_seq.sv | 149 ++++++++++++++
 tb/tb_rg_mac_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rg_mac_seq.sv
// rg_mac_seq: row sequencer and multiply-accumulate stage behind the weight ROM.
// Walks the ROM rows once per pass, accumulating UNITS_NUM dot products of the
// streamed activation against each row, then presents a saturated result
// vector under a valid/ready handshake.
module rg_mac_seq #(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = 5,
  parameter int ROWS      = 180,
  parameter int FRAC_BITS = 16,
  parameter int ACC_WL    = 56
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [D_WL-1:0]           x_i,
  input  logic                      x_valid,
  output logic                      x_ready,
  output logic [7:0]                addr,
  input  logic [UNITS_NUM*D_WL-1:0] w_i,
  output logic [UNITS_NUM*D_WL-1:0] y_o,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic                      busy
);

  localparam int              PROD_WL   = 2 * D_WL;
  localparam logic [7:0]      LAST_ADDR = 8'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg;
  logic [7:0] addr_reg;
  logic       x_ready_reg;
  logic       y_valid_reg;
  logic       busy_reg;

  logic acc_clr;
  logic beat;
  logic last_beat;

  // A beat only exists in RUN; x_ready_reg is high exactly there.
  assign acc_clr   = (state_reg == IDLE) && start;
  assign beat      = (state_reg == RUN) && x_valid && x_ready_reg;
  assign last_beat = beat && (addr_reg == LAST_ADDR);

  assign addr    = addr_reg;
  assign x_ready = x_ready_reg;
  assign y_valid = y_valid_reg;
  assign busy    = busy_reg;

  // Pass control: IDLE -> RUN on start, RUN -> DONE on the last row, DONE -> IDLE on y handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= 8'd0;
      x_ready_reg <= 1'b0;
      y_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= RUN;
            addr_reg    <= 8'd0;
            x_ready_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        RUN: begin
          if (beat) begin
            if (addr_reg == LAST_ADDR) begin
              state_reg   <= DONE;
              addr_reg    <= 8'd0;
              x_ready_reg <= 1'b0;
              y_valid_reg <= 1'b1;
            end else begin
              addr_reg <= addr_reg + 8'd1;
            end
          end
        end
        DONE: begin
          if (y_ready) begin
            state_reg   <= IDLE;
            y_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          addr_reg    <= 8'd0;
          x_ready_reg <= 1'b0;
          y_valid_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  // One multiply-accumulate lane per output unit.
  for (genvar gi = 0; gi < UNITS_NUM; gi++) begin : g_unit
    logic signed [D_WL-1:0]    w_u;
    logic signed [PROD_WL-1:0] prod;
    logic signed [ACC_WL-1:0]  prod_ext;
    logic signed [ACC_WL-1:0]  acc_reg;
    logic signed [ACC_WL-1:0]  acc_next;
    logic signed [ACC_WL-1:0]  r;
    logic [ACC_WL-D_WL:0]      r_hi;
    logic [D_WL-1:0]           y_next;
    logic [D_WL-1:0]           y_reg;

    assign w_u      = $signed(w_i[gi*D_WL +: D_WL]);
    assign prod     = $signed(x_i) * w_u;
    assign prod_ext = {{(ACC_WL-PROD_WL){prod[PROD_WL-1]}}, prod};
    // acc_next includes the current beat so the final row lands in y without a bubble.
    assign acc_next = acc_reg + prod_ext;
    assign r        = acc_next >>> FRAC_BITS;
    // r fits in D_WL bits only when every bit from the D_WL sign position up is equal.
    assign r_hi     = r[ACC_WL-1:D_WL-1];

    // Clamp the rescaled sum to the signed D_WL range.
    always_comb begin
      y_next = r[D_WL-1:0];
      if (!((&r_hi) || !(|r_hi))) begin
        if (r[ACC_WL-1]) y_next = {1'b1, {(D_WL-1){1'b0}}};
        else             y_next = {1'b0, {(D_WL-1){1'b1}}};
      end
    end

    // Accumulate on beats, clear at pass start, capture the result on the last beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_reg <= '0;
        y_reg   <= '0;
      end else begin
        if (acc_clr) begin
          acc_reg <= '0;
        end else if (beat) begin
          acc_reg <= acc_next;
        end
        if (last_beat) begin
          y_reg <= y_next;
        end
      end
    end

    assign y_o[gi*D_WL +: D_WL] = y_reg;
  end

endmodule

// File: tb/tb_rg_mac_seq.sv
// Directed testbench for rg_mac_seq: impulse, full-pass, saturation,
// backpressure, mid-pass reset, back-to-back passes and a ROWS=1 build.
module tb_rg_mac_seq;

  localparam int ROWS = 180;
  localparam logic [119:0] ROW0     = 120'h0004c6_fffe35_fff6f0_fff4af_0008e3;
  localparam logic [119:0] EXP_NEG  = 120'hFFFB3A_0001CB_000910_000B51_FFF71D;
  localparam logic [119:0] EXP_FULL = {5{24'h00B400}};
  localparam logic [119:0] EXP_SATP = {5{24'h7FFFFF}};
  localparam logic [119:0] EXP_SATN = {5{24'h800000}};
  localparam logic [119:0] EXP_RAMP = 120'h004272_0041BE_00410A_004056_003FA2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [23:0]  x_i;
  logic         x_valid;
  logic         x_ready;
  logic [7:0]   addr;
  logic [119:0] w_i;
  logic [119:0] y_o;
  logic         y_valid;
  logic         y_ready;
  logic         busy;

  logic         start1;
  logic [23:0]  x_i1;
  logic         x_valid1;
  logic         x_ready1;
  logic [7:0]   addr1;
  logic [119:0] w1;
  logic [119:0] y1;
  logic         y_valid1;
  logic         y_ready1;
  logic         busy1;

  int           rom_mode;
  logic [23:0]  stub_w;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  rg_mac_seq #(.ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .x_i(x_i), .x_valid(x_valid),
    .x_ready(x_ready), .addr(addr), .w_i(w_i), .y_o(y_o), .y_valid(y_valid),
    .y_ready(y_ready), .busy(busy)
  );

  rg_mac_seq #(.ROWS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x_i(x_i1), .x_valid(x_valid1),
    .x_ready(x_ready1), .addr(addr1), .w_i(w1), .y_o(y1), .y_valid(y_valid1),
    .y_ready(y_ready1), .busy(busy1)
  );

  assign w1 = ROW0;

  // Combinational ROM model.
  always_comb begin
    w_i = '0;
    case (rom_mode)
      0:       w_i = (addr == 8'd0) ? ROW0 : {5{24'h012345}};
      1:       w_i = {5{stub_w}};
      default: begin
        for (int u = 0; u < 5; u++) w_i[u*24 +: 24] = 24'(addr) + 24'(u + 1);
      end
    endcase
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_units(input string tag, input logic [119:0] got, input logic [119:0] exp);
    for (int u = 0; u < 5; u++)
      check($sformatf("%s_u%0d", tag, u), got[u*24 +: 24], exp[u*24 +: 24]);
  endtask

  // One pass: xsel 0 = impulse on row 0, 1 = constant xa on every row.
  task automatic run_pass(input string tag, input int xsel, input logic [23:0] xa,
                          input bit gaps, input int yhold, input logic [119:0] exp);
    int rowc = 0;
    int cyc = 0;
    int addr_err = 0;
    int stall_err = 0;
    bit b;
    logic [119:0] y_cap;
    start = 1'b1; x_valid = 1'b0; y_ready = 1'b0;
    step();
    start = 1'b0; cyc = 1;
    check({tag, "_x_ready_run"}, x_ready, 1);
    check({tag, "_busy_run"}, busy, 1);
    while (!y_valid && cyc < 2000) begin
      if (addr != 8'(rowc)) addr_err++;
      x_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      x_i = (xsel == 0) ? ((rowc == 0) ? xa : 24'h0) : xa;
      if (gaps) start = ($urandom_range(0, 7) == 0);
      b = x_valid & x_ready;
      step();
      if (b) rowc++;
      cyc++;
    end
    start = 1'b0; x_valid = 1'b0;
    check({tag, "_addr_track"}, addr_err, 0);
    check({tag, "_beats"}, rowc, ROWS);
    check({tag, "_y_valid"}, y_valid, 1);
    if (!gaps) check({tag, "_latency"}, cyc, ROWS + 1);
    check_units(tag, y_o, exp);
    y_cap = y_o;
    for (int i = 0; i < yhold; i++) begin
      start = (i % 5 == 0);
      step();
      if (y_o !== y_cap || !y_valid) stall_err++;
    end
    check({tag, "_y_stable"}, stall_err, 0);
    y_ready = 1'b1; start = 1'b1;
    step();
    y_ready = 1'b0; start = 1'b0;
    check({tag, "_y_valid_drop"}, y_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_y_hold_idle"}, y_o, y_cap);
    $display("pass %s: %0d cycles to y_valid, y_o=%h", tag, cyc, y_cap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; x_i = '0; x_valid = 1'b0; y_ready = 1'b0;
    start1 = 1'b0; x_i1 = '0; x_valid1 = 1'b0; y_ready1 = 1'b0;
    rom_mode = 0; stub_w = '0;
    step(); step();
    check("rst_addr", addr, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_x_ready", x_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_y_o", y_o, 0);
    rst = 1'b0;
    step();

    rom_mode = 0;
    run_pass("impulse", 0, 24'h010000, 1'b0, 3, ROW0);
    run_pass("neg_impulse", 0, 24'hFF0000, 1'b0, 0, EXP_NEG);

    rom_mode = 1; stub_w = 24'h000100;
    run_pass("full", 1, 24'h010000, 1'b0, 0, EXP_FULL);
    stub_w = 24'h7FFFFF;
    run_pass("sat_pos", 1, 24'h7FFFFF, 1'b0, 0, EXP_SATP);
    run_pass("sat_neg", 1, 24'h800000, 1'b0, 0, EXP_SATN);

    rom_mode = 2;
    run_pass("ramp", 1, 24'h010000, 1'b0, 0, EXP_RAMP);
    run_pass("ramp_gaps", 1, 24'h010000, 1'b1, 20, EXP_RAMP);

    // Abort a pass at row 90 with an asynchronous reset between edges.
    start = 1'b1;
    step();
    start = 1'b0; x_valid = 1'b1; x_i = 24'h010000;
    n = 0;
    while (addr != 8'd90 && n < 300) begin
      step();
      n++;
    end
    check("abort_reached_90", addr, 90);
    #2 rst = 1'b1;
    #1;
    check("abort_addr", addr, 0);
    check("abort_y_valid", y_valid, 0);
    check("abort_x_ready", x_ready, 0);
    check("abort_busy", busy, 0);
    #1 rst = 1'b0;
    x_valid = 1'b0;
    step();
    $display("abort: reset applied at addr 90");
    run_pass("after_abort", 1, 24'h010000, 1'b0, 0, EXP_RAMP);

    // ROWS=1 build: start, one beat, result on the second cycle.
    start1 = 1'b1;
    step();
    start1 = 1'b0; x_valid1 = 1'b1; x_i1 = 24'h010000;
    check("r1_x_ready", x_ready1, 1);
    step();
    x_valid1 = 1'b0;
    check("r1_y_valid", y_valid1, 1);
    check("r1_addr", addr1, 0);
    check_units("r1", y1, ROW0);
    y_ready1 = 1'b1;
    step();
    y_ready1 = 1'b0;
    check("r1_y_valid_drop", y_valid1, 0);
    $display("pass rows1: y_o=%h", y1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
